// File: rtl/upct_plru_n_if.sv
// Bus between the upper-PC table and its users. This covers the RESP-stage
// read/observer ports, the update0/update1 path and the flush request.
interface upct_plru_n_if #(
  parameter int ENTRIES     = 8,
  parameter int LOG_ENTRIES = $clog2(ENTRIES),
  parameter int UPPER_WIDTH = 20,
  parameter int N_OBS       = 2
);
  logic                         read_valid_RESP;
  logic [LOG_ENTRIES-1:0]       read_index_RESP;
  logic [N_OBS*LOG_ENTRIES-1:0] observer_index_RESP;
  logic [N_OBS*UPPER_WIDTH-1:0] observer_upper_PC_RESP;
  logic                         update0_valid;
  logic [31:0]                  update0_start_full_PC;
  logic                         flush_valid;
  logic                         update1_valid;
  logic                         update1_hit;
  logic [LOG_ENTRIES-1:0]       update1_upct_index;

  // Requester side: fetch/predictor logic driving the table
  modport master (
    output read_valid_RESP, read_index_RESP, observer_index_RESP,
           update0_valid, update0_start_full_PC, flush_valid,
    input  observer_upper_PC_RESP, update1_valid, update1_hit, update1_upct_index
  );

  // Table side
  modport slave (
    input  read_valid_RESP, read_index_RESP, observer_index_RESP,
           update0_valid, update0_start_full_PC, flush_valid,
    output observer_upper_PC_RESP, update1_valid, update1_hit, update1_upct_index
  );
endinterface

// File: rtl/upct_plru_n.sv
// Upper-PC table: stores distinct upper PC bits so that other structures only
// need to keep a short index. Replacement uses the lowest invalid entry first,
// then a tree-PLRU victim. Updates take two stages (update0 lookup, update1
// commit), with a bypass so back-to-back identical PCs never duplicate an entry.
module upct_plru_n #(
  parameter int ENTRIES     = 8,
  parameter int LOG_ENTRIES = $clog2(ENTRIES),
  parameter int UPPER_WIDTH = 20,
  parameter int N_OBS       = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  upct_plru_n_if.slave  bus
);

  typedef logic [ENTRIES-1:1]     tree_t;   // heap-ordered PLRU nodes, root = 1
  typedef logic [LOG_ENTRIES-1:0] idx_t;
  typedef logic [UPPER_WIDTH-1:0] upper_t;

  localparam logic [ENTRIES-1:0] ONE_HOT0 = {{(ENTRIES-1){1'b0}}, 1'b1};

  // Set every node on idx's root-to-leaf path to point away from idx.
  function automatic tree_t plru_touch(input tree_t t, input idx_t idx);
    tree_t r;
    idx_t  node;
    r = t;
    for (int l = 0; l < LOG_ENTRIES; l++) begin
      node    = (idx_t'(1) << l) | (idx >> (LOG_ENTRIES - l));
      r[node] = ~idx[LOG_ENTRIES-1-l];
    end
    return r;
  endfunction

  // Walk from the root following the node bits; the leaf reached is the victim.
  function automatic idx_t plru_victim(input tree_t t);
    idx_t v;
    idx_t node;
    v = '0;
    for (int l = 0; l < LOG_ENTRIES; l++) begin
      node                = (idx_t'(1) << l) | (v >> (LOG_ENTRIES - l));
      v[LOG_ENTRIES-1-l]  = t[node];
    end
    return v;
  endfunction

  // Index of the lowest set bit (0 when none is set).
  function automatic idx_t lowest_set(input logic [ENTRIES-1:0] vec);
    idx_t r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      r = vec[i] ? idx_t'(i) : r;
    end
    return r;
  endfunction

  upper_t             array_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  tree_t              plru_q, plru_d;
  logic               u1_valid_q;
  upper_t             u1_upper_q;
  logic [ENTRIES-1:0] u1_match_q, u1_match_d;

  upper_t             u0_upper_s;
  logic [ENTRIES-1:0] match_raw_s;
  logic               u1_eff_s;
  logic               u1_any_hit_s;
  logic               u1_alloc_s;
  idx_t               hit_idx_s;
  idx_t               alloc_idx_s;
  idx_t               u1_idx_s;
  logic               unused_pc_low_s;

  // Only the upper PC bits are stored; the page offset is deliberately ignored.
  assign unused_pc_low_s = ^bus.update0_start_full_PC[31-UPPER_WIDTH:0];

  // Update0 lookup and update1 decision (hit index, or allocation index).
  always_comb begin
    u0_upper_s  = bus.update0_start_full_PC[31:32-UPPER_WIDTH];
    match_raw_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_raw_s[i] = valid_q[i] & (array_q[i] == u0_upper_s);
    end
    u1_eff_s     = u1_valid_q & ~bus.flush_valid;
    u1_any_hit_s = |u1_match_q;
    hit_idx_s    = lowest_set(u1_match_q);
    alloc_idx_s  = (&valid_q) ? plru_victim(plru_q) : lowest_set(~valid_q);
    u1_idx_s     = (u1_eff_s & u1_any_hit_s) ? hit_idx_s : alloc_idx_s;
    u1_alloc_s   = u1_eff_s & ~u1_any_hit_s;
  end

  // Match vector handed to update1. This includes the bypass of the allocation
  // happening this cycle. It also clears a match on an entry that is being
  // overwritten with a different upper PC in this same cycle.
  always_comb begin
    u1_match_d = match_raw_s;
    if (bus.flush_valid) begin
      u1_match_d = '0;
    end else if (u1_alloc_s) begin
      if (u1_upper_q == u0_upper_s) begin
        u1_match_d = ONE_HOT0 << u1_idx_s;
      end else begin
        u1_match_d[u1_idx_s] = 1'b0;
      end
    end else begin
      u1_match_d = match_raw_s;
    end
  end

  // Next valid/PLRU state. Priority: flush, then update1, then the RESP read touch.
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (bus.flush_valid) begin
      valid_d = '0;
      plru_d  = '0;
    end else if (u1_eff_s) begin
      plru_d = plru_touch(plru_q, u1_idx_s);
      if (u1_alloc_s) begin
        valid_d[u1_idx_s] = 1'b1;
      end else begin
        valid_d = valid_q;
      end
    end else if (bus.read_valid_RESP) begin
      plru_d = plru_touch(plru_q, bus.read_index_RESP);
    end else begin
      plru_d = plru_q;
    end
  end

  // Table state and update1 pipeline registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= '0;
      plru_q     <= '0;
      u1_valid_q <= 1'b0;
      u1_upper_q <= '0;
      u1_match_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        array_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      plru_q     <= plru_d;
      u1_valid_q <= bus.update0_valid;
      u1_upper_q <= u0_upper_s;
      u1_match_q <= u1_match_d;
      if (u1_alloc_s) begin
        array_q[u1_idx_s] <= u1_upper_q;
      end
    end
  end

  // Update1 result and observer read ports. Observers read the array directly,
  // with no same-cycle write bypass.
  always_comb begin
    bus.update1_valid          = u1_eff_s;
    bus.update1_hit            = u1_eff_s & u1_any_hit_s;
    bus.update1_upct_index     = u1_idx_s;
    bus.observer_upper_PC_RESP = '0;
    for (int k = 0; k < N_OBS; k++) begin
      bus.observer_upper_PC_RESP[k*UPPER_WIDTH +: UPPER_WIDTH] =
        array_q[bus.observer_index_RESP[k*LOG_ENTRIES +: LOG_ENTRIES]];
    end
  end

endmodule

// File: tb/tb_upct_plru_n.sv
// Bench for upct_plru_n. It runs directed scenarios with fixed expected values,
// then a randomized run. Every cycle is checked against a table model that
// works on address ranges. Each update is looked up at commit time against the
// model's current contents.
module tb_upct_plru_n;

  localparam int E  = 8;
  localparam int L  = 3;
  localparam int UW = 20;
  localparam int NO = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  upct_plru_n_if #(.ENTRIES(E), .LOG_ENTRIES(L), .UPPER_WIDTH(UW), .N_OBS(NO)) bus ();

  upct_plru_n #(.ENTRIES(E), .LOG_ENTRIES(L), .UPPER_WIDTH(UW), .N_OBS(NO)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_arr  [E];
  bit m_val  [E];
  bit m_tree [E];   // node 1..E-1 used
  bit m_u1v;
  int m_u1u;

  int act_v, act_h, act_i;
  int act_obs [NO];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_victim();
    int lo = 0, hi = E, node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_tree[node]) begin lo = mid; node = 2 * node + 1; end
      else begin hi = mid; node = 2 * node; end
    end
    return lo;
  endfunction

  function automatic void m_touch(input int idx);
    int lo = 0, hi = E, node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (idx < mid) begin m_tree[node] = 1'b1; hi = mid; node = 2 * node; end
      else begin m_tree[node] = 1'b0; lo = mid; node = 2 * node + 1; end
    end
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < E; i++) if (!m_val[i]) return i;
    return m_victim();
  endfunction

  function automatic int m_lookup(input int u);
    for (int i = 0; i < E; i++) if (m_val[i] && m_arr[i] == u) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < E; i++) begin m_arr[i] = 0; m_val[i] = 1'b0; m_tree[i] = 1'b0; end
    m_u1v = 1'b0;
    m_u1u = 0;
  endfunction

  task automatic drive(input bit rv, input int ridx, input bit u0v, input logic [31:0] pc,
                       input bit fl, input int o0, input int o1);
    bus.read_valid_RESP       = rv;
    bus.read_index_RESP       = L'(ridx);
    bus.update0_valid         = u0v;
    bus.update0_start_full_PC = pc;
    bus.flush_valid           = fl;
    bus.observer_index_RESP   = {L'(o1), L'(o0)};
  endtask

  // One clock cycle: drive, check at negedge against the model, advance the model.
  task automatic step(input bit rv, input int ridx, input bit u0v, input logic [31:0] pc,
                      input bit fl, input int o0, input int o1);
    bit eff, found;
    int hidx, exp_idx;
    drive(rv, ridx, u0v, pc, fl, o0, o1);
    @(negedge clk);
    eff     = m_u1v && !fl;
    hidx    = m_lookup(m_u1u);
    found   = eff && (hidx >= 0);
    exp_idx = found ? hidx : m_alloc();
    act_v   = int'(bus.update1_valid);
    act_h   = int'(bus.update1_hit);
    act_i   = int'(bus.update1_upct_index);
    for (int k = 0; k < NO; k++) act_obs[k] = int'(bus.observer_upper_PC_RESP[k*UW +: UW]);
    check_eq("u1_valid", act_v, int'(eff));
    check_eq("u1_hit", act_h, int'(found));
    check_eq("u1_index", act_i, exp_idx);
    check_eq("obs0", act_obs[0], m_arr[o0]);
    check_eq("obs1", act_obs[1], m_arr[o1]);
    if (fl) begin
      for (int i = 0; i < E; i++) begin m_val[i] = 1'b0; m_tree[i] = 1'b0; end
    end else if (eff) begin
      if (!found) begin m_arr[exp_idx] = m_u1u; m_val[exp_idx] = 1'b1; end
      m_touch(exp_idx);
    end else if (rv) begin
      m_touch(ridx);
    end
    m_u1v = u0v;
    m_u1u = int'(pc[31:12]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int o0, input int o1);
    step(1'b0, 0, 1'b0, 32'h0, 1'b0, o0, o1);
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 0, 1);
    nrst = 1'b0;
    #1;
    check_eq("rst_u1_valid", int'(bus.update1_valid), 0);
    check_eq("rst_u1_hit", int'(bus.update1_hit), 0);
    check_eq("rst_u1_index", int'(bus.update1_upct_index), 0);
    check_eq("rst_obs", int'(bus.observer_upper_PC_RESP), 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic fill();
    for (int i = 0; i < E; i++) step(1'b0, 0, 1'b1, 32'((i + 1) << 12), 1'b0, 0, 1);
    idle(0, 1);
  endtask

  initial begin
    int cnt;
    m_reset();

    // First allocation and observer read-back
    do_reset();
    step(1'b0, 0, 1'b1, 32'h1234_5000, 1'b0, 0, 1);
    idle(0, 1);
    check_eq("t1_valid", act_v, 1);
    check_eq("t1_hit", act_h, 0);
    check_eq("t1_index", act_i, 0);
    idle(0, 1);
    check_eq("t1_obs0", act_obs[0], 32'h12345);

    // Fill in order, then a plain miss takes the PLRU victim 0
    do_reset();
    for (int i = 0; i <= E; i++) begin
      step(1'b0, 0, i < E, 32'((i + 1) << 12), 1'b0, 0, 1);
      if (i >= 1) begin
        check_eq("fill_index", act_i, i - 1);
        check_eq("fill_hit", act_h, 0);
      end
    end
    for (int j = 0; j < E / 2; j++) begin
      idle(2 * j, 2 * j + 1);
      check_eq("fill_obs0", act_obs[0], 2 * j + 1);
      check_eq("fill_obs1", act_obs[1], 2 * j + 2);
    end
    step(1'b0, 0, 1'b1, 32'h0009_9000, 1'b0, 0, 1);
    idle(0, 1);
    check_eq("plru_miss_index", act_i, 0);

    // Read touch of index 0 before the miss moves the victim to 4
    do_reset();
    fill();
    step(1'b1, 0, 1'b1, 32'h0009_9000, 1'b0, 0, 1);
    idle(0, 1);
    check_eq("plru_touch_index", act_i, 4);
    check_eq("plru_touch_hit", act_h, 0);

    // Update1 hit on 2 beats the read touch of 6
    do_reset();
    fill();
    step(1'b0, 0, 1'b1, 32'h0000_3000, 1'b0, 0, 1);
    step(1'b1, 6, 1'b1, 32'h0009_9000, 1'b0, 0, 1);
    check_eq("prio_hit", act_h, 1);
    check_eq("prio_index", act_i, 2);
    idle(0, 1);
    check_eq("prio_victim", act_i, 4);

    // Same PC on back-to-back update0s gives one entry only
    do_reset();
    step(1'b0, 0, 1'b1, 32'hABCD_E000, 1'b0, 0, 1);
    step(1'b0, 0, 1'b1, 32'hABCD_E123, 1'b0, 0, 1);
    check_eq("dup_hit0", act_h, 0);
    check_eq("dup_index0", act_i, 0);
    idle(0, 1);
    check_eq("dup_hit1", act_h, 1);
    check_eq("dup_index1", act_i, 0);
    cnt = 0;
    for (int j = 0; j < E / 2; j++) begin
      idle(2 * j, 2 * j + 1);
      cnt += (act_obs[0] == 32'hABCDE) ? 1 : 0;
      cnt += (act_obs[1] == 32'hABCDE) ? 1 : 0;
    end
    check_eq("dup_count", cnt, 1);

    // Flush cancels an update1 miss; the table restarts empty
    do_reset();
    fill();
    step(1'b0, 0, 1'b1, 32'h0009_9000, 1'b0, 0, 1);
    step(1'b0, 0, 1'b0, 32'h0, 1'b1, 0, 1);
    check_eq("flush_valid", act_v, 0);
    step(1'b0, 0, 1'b1, 32'h0000_3000, 1'b0, 0, 1);
    check_eq("flush_nowrite", act_obs[0], 32'h00001);
    idle(0, 1);
    check_eq("flush_valid_after", act_v, 1);
    check_eq("flush_hit_after", act_h, 0);
    check_eq("flush_index_after", act_i, 0);

    // Randomized run, with a reset partway through
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, E - 1)),
           $urandom_range(0, 9) < 7,
           (32'($urandom_range(0, 12)) << 12) | 32'($urandom_range(0, 4095)),
           $urandom_range(0, 31) == 0,
           int'($urandom_range(0, E - 1)), int'($urandom_range(0, E - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/upct_plru_n.md
Name: upct_plru_n

Overview:
- Parametrised upper-PC table. Stores distinct upper PC bits so fetch and branch-prediction structures keep only a short table index.
- Generalises the 8-entry, 2-observer table:
  - ENTRIES-deep tree-PLRU of any power-of-2 depth.
  - N_OBS read observers.
  - Per-entry valid bits with invalid-first allocation.
  - Global flush.
  - Update0→update1 bypass, so back-to-back updates with the same upper PC cannot create duplicate entries.
- Sits beside the fetch RESP stage and the predictor update path.

Parameters:
- ENTRIES, 8, table depth; power of 2, ≥2.
- LOG_ENTRIES, $clog2(ENTRIES), index width.
- UPPER_WIDTH, 20, stored upper PC bits, taken from PC[31:32-UPPER_WIDTH].
- N_OBS, 2, number of combinational observer read ports.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- read_valid_RESP  in  1  RESP-stage table use; PLRU touch request.
- read_index_RESP  in  LOG_ENTRIES  index being used.
- observer_index_RESP  in  N_OBS*LOG_ENTRIES  per-observer index, packed; observer k at [k*LOG_ENTRIES +: LOG_ENTRIES].
- observer_upper_PC_RESP  out  N_OBS*UPPER_WIDTH  per-observer stored upper PC, packed the same way.
- update0_valid  in  1  update request.
- update0_start_full_PC  in  32  full PC of the update.
- flush_valid  in  1  invalidate the whole table.
- update1_valid  out  1  update1 result valid.
- update1_hit  out  1  1 = existing entry matched; 0 = entry allocated.
- update1_upct_index  out  LOG_ENTRIES  index holding the upper PC.

Behaviour:
- Reset state:
  - array = 0, valid = 0, all PLRU bits = 0.
  - update1 stage registers = 0.
  - Outputs: update1_valid = 0, update1_hit = 0, update1_upct_index = 0, observers = 0.
- PLRU tree:
  - ENTRIES-1 bits, heap order: node 1 is the root; children of node n are 2n and 2n+1.
  - Node bit 0 = victim in the lower half; 1 = victim in the upper half.
  - Victim: walk from the root following bit values.
  - Touch(idx): every node on idx's path is set to point away from idx, i.e. bit = ~(idx bit at that level).
- Observers: combinational, upct_array[observer_index]. No same-cycle write bypass; an allocation is visible the cycle after update1.
- Update0 (cycle T):
  - u0 = PC[31:32-UPPER_WIDTH].
  - match_vec[i] = valid[i] & (array[i] == u0).
  - Bypass: if update1 is allocating in cycle T and its PC equals u0, the registered match_vec becomes one-hot of the allocated index.
  - valid, u0 and match_vec are registered into update1.
- Update1 (cycle T+1; 1-cycle latency; outputs combinational from update1 registers and current state):
  - Hit (any match):
    - index = lowest set bit of match_vec; update1_hit = 1.
    - Touch(index). No array write.
  - Miss:
    - index = lowest invalid entry if any, else the PLRU victim.
    - array[index] = u0, valid[index] = 1, Touch(index); update1_hit = 0.
  - update1_valid = registered update0_valid.
  - When update1 is not valid: update1_upct_index still shows the would-be allocation index (lowest invalid, else victim) and update1_hit = 0.
- RESP touch: Touch(read_index_RESP) only when update1 is not valid that cycle; update1 has priority, the read touch is dropped.
- Flush (highest priority):
  - In the flush cycle: update1_valid is forced to 0; no array write, no touch.
  - Next cycle: all valid = 0, all PLRU bits = 0; array contents are retained (observers still read stale data).
  - An update0 in the flush cycle is captured with match_vec = 0 and bypass suppressed; it allocates in the next cycle.
- nRST asserted mid-operation: immediate return to the reset state; any in-flight update1 is discarded.

Test Plan:
- Reset, then update0 PC=0x12345000 → next cycle: update1_valid=1, hit=0, index=0. Following cycle: observer0 index 0 returns 0x12345.
- 8 consecutive distinct updates, upper PCs 0x00001..0x00008 → indices 0..7 in order, all hit=0. Observers read back each value.
- Same-PC back-to-back: update0 PC=0xABCDE000 on cycles T and T+1 → T+1: hit=0, index=8-entry allocation k. T+2: hit=1, index=k. Exactly one entry holds 0xABCDE.
- PLRU: after the full fill 0..7, a new miss → index 0. Instead, with read_valid_RESP index 0 (no update1 active) before the miss → miss allocates index 4.
- Read-touch priority: read_valid_RESP index 6 in the same cycle as an update1 hit on index 2 → PLRU reflects Touch(2) only.
- Flush in the same cycle as an update1 miss → update1_valid=0, no write. A subsequent update of a previously stored PC → hit=0, index=0.
